// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter that merges NUM_PORTS user word streams into one BFT
// output packet register. It applies per-port credit flow control, keeps a
// per-port sequence number and uses a small route table that supplies each
// port's destination leaf and port.
module leaf_out_arbiter #(
    parameter int unsigned NUM_PORTS     = 4,
    parameter int unsigned PAYLOAD_BITS  = 32,
    parameter int unsigned NUM_LEAF_BITS = 5,
    parameter int unsigned NUM_PORT_BITS = 4,
    parameter int unsigned NUM_ADDR_BITS = 7,
    parameter int unsigned PACKET_BITS   = 49,
    parameter int unsigned CREDITS       = 64,
    localparam int unsigned IDX_BITS     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                              clk_user,
    input  logic                              reset,
    input  logic [NUM_PORTS*PAYLOAD_BITS-1:0] din_user2arb,
    input  logic [NUM_PORTS-1:0]              vld_user2arb,
    output logic [NUM_PORTS-1:0]              ack_arb2user,
    input  logic                              cfg_we,
    input  logic [IDX_BITS-1:0]               cfg_idx,
    input  logic                              cfg_en,
    input  logic [NUM_LEAF_BITS-1:0]          cfg_leaf,
    input  logic [NUM_PORT_BITS-1:0]          cfg_port,
    input  logic [NUM_PORTS-1:0]              credit_ret,
    output logic [PACKET_BITS-1:0]            pkt_out,
    input  logic                              pkt_rdy,
    output logic                              busy
);

    localparam int unsigned CREDIT_BITS = $clog2(CREDITS + 1);
    localparam int unsigned VLD_BIT     = PACKET_BITS - 1;

    logic [NUM_PORTS-1:0]     en_q;
    logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_PORTS];
    logic [NUM_PORT_BITS-1:0] port_q   [NUM_PORTS];
    logic [CREDIT_BITS-1:0]   credit_q [NUM_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_q    [NUM_PORTS];
    logic [PAYLOAD_BITS-1:0]  word     [NUM_PORTS];
    logic [IDX_BITS-1:0]      last_q;
    logic [PACKET_BITS-1:0]   pkt_q, pkt_d;

    logic                     out_free;
    logic [NUM_PORTS-1:0]     eligible;
    logic                     grant_vld;
    logic [IDX_BITS-1:0]      grant_idx;

    // Unpack the flat user bus and form per-port eligibility.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign word[i]     = din_user2arb[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        assign eligible[i] = vld_user2arb[i] & en_q[i] & (credit_q[i] != '0) & out_free;
    end

    // The output register may be refilled in the same cycle it is drained.
    assign out_free = ~pkt_q[VLD_BIT] | pkt_rdy;
    assign pkt_out  = pkt_q;
    assign busy     = pkt_q[VLD_BIT];

    // Round-robin search starting just after the last granted port.
    always_comb begin
        logic [IDX_BITS-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            cand = IDX_BITS'((32'(last_q) + k) % NUM_PORTS);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // One-hot accept toward the granted user port.
    always_comb begin
        ack_arb2user = '0;
        if (grant_vld) begin
            ack_arb2user[grant_idx] = 1'b1;
        end
    end

    // Next packet: load on grant, drop valid when drained with nothing to send.
    always_comb begin
        pkt_d = pkt_q;
        if (grant_vld) begin
            pkt_d = {1'b1, leaf_q[grant_idx], port_q[grant_idx], seq_q[grant_idx],
                     word[grant_idx]};
        end else if (out_free) begin
            pkt_d[VLD_BIT] = 1'b0;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            pkt_q  <= '0;
            last_q <= IDX_BITS'(NUM_PORTS - 1);
        end else begin
            pkt_q <= pkt_d;
            if (grant_vld) begin
                last_q <= grant_idx;
            end
        end
    end

    // Route table; a write lands at the edge so the packet loaded there uses old values.
    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            en_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                leaf_q[i] <= '0;
                port_q[i] <= '0;
            end
        end else if (cfg_we) begin
            en_q[cfg_idx]   <= cfg_en;
            leaf_q[cfg_idx] <= cfg_leaf;
            port_q[cfg_idx] <= cfg_port;
        end
    end

    // Per-port credits (grant and return cancel) and sequence counters.
    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                credit_q[i] <= CREDIT_BITS'(CREDITS);
                seq_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                unique case ({ack_arb2user[i], credit_ret[i]})
                    2'b10: credit_q[i] <= credit_q[i] - CREDIT_BITS'(1);
                    2'b01: begin
                        if (credit_q[i] != CREDIT_BITS'(CREDITS)) begin
                            credit_q[i] <= credit_q[i] + CREDIT_BITS'(1);
                        end
                    end
                    default: credit_q[i] <= credit_q[i];
                endcase
                if (ack_arb2user[i]) begin
                    seq_q[i] <= seq_q[i] + NUM_ADDR_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter. Stimulus checks acks and pushes the
// expected packet for each grant; a monitor pops and compares on each handshake.
module tb_leaf_out_arbiter;

    localparam int NP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   data [NP];
    logic [127:0]  din;
    logic [3:0]    vld, ack, credit_ret;
    logic          cfg_we, cfg_en;
    logic [1:0]    cfg_idx;
    logic [4:0]    cfg_leaf;
    logic [3:0]    cfg_port;
    logic [48:0]   pkt_out;
    logic          pkt_rdy, busy;

    logic [48:0]   exp_q [$];
    logic [48:0]   mon_exp;
    logic [48:0]   held;
    logic [4:0]    m_leaf [NP];
    logic [3:0]    m_port [NP];
    logic [6:0]    m_seq  [NP];
    int            n_checks = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    assign din = {data[3], data[2], data[1], data[0]};

    leaf_out_arbiter dut (
        .clk_user     (clk),
        .reset        (reset),
        .din_user2arb (din),
        .vld_user2arb (vld),
        .ack_arb2user (ack),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_en       (cfg_en),
        .cfg_leaf     (cfg_leaf),
        .cfg_port     (cfg_port),
        .credit_ret   (credit_ret),
        .pkt_out      (pkt_out),
        .pkt_rdy      (pkt_rdy),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every accepted packet must match the oldest expected one.
    always @(negedge clk) begin
        if (reset && pkt_out[48] && pkt_rdy) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_bad++;
                $display("FAIL pkt_unexpected: got %0h want none at %0t", pkt_out, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pkt", 64'(pkt_out), 64'(mon_exp));
            end
        end
    end

    task automatic model_clear();
        exp_q.delete();
        for (int i = 0; i < NP; i++) begin
            m_leaf[i] = '0;
            m_port[i] = '0;
            m_seq[i]  = '0;
        end
    endtask

    // One cycle: check the acks at mid-cycle and queue the packet a grant should produce.
    task automatic step(input logic [3:0] exp_ack, input string name);
        int g;
        @(negedge clk);
        check(name, 64'(ack), 64'(exp_ack));
        if (exp_ack != 4'b0) begin
            g = 0;
            for (int i = 0; i < NP; i++) if (exp_ack[i]) g = i;
            exp_q.push_back({1'b1, m_leaf[g], m_port[g], m_seq[g], data[g]});
            m_seq[g] = m_seq[g] + 7'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input logic en, input logic [4:0] leaf,
                             input logic [3:0] port);
        cfg_we   = 1'b1;
        cfg_idx  = 2'(idx);
        cfg_en   = en;
        cfg_leaf = leaf;
        cfg_port = port;
        step(4'b0000, "cfg_noack");
        cfg_we = 1'b0;
        m_leaf[idx] = leaf;
        m_port[idx] = port;
    endtask

    task automatic do_reset();
        vld        = 4'b0;
        credit_ret = 4'b0;
        pkt_rdy    = 1'b1;
        reset      = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vld = 4'hF; credit_ret = 4'b0; pkt_rdy = 1'b0;
        cfg_we = 1'b0; cfg_en = 1'b0; cfg_idx = '0; cfg_leaf = '0; cfg_port = '0;
        for (int i = 0; i < NP; i++) data[i] = 32'h0;
        model_clear();
        #1 reset = 1'b0;
        #11;
        check("rst_ack", 64'(ack), 64'(0));
        check("rst_pkt", 64'(pkt_out), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1; vld = 4'b0; pkt_rdy = 1'b1;

        // Single port
        cfg_write(0, 1'b1, 5'd3, 4'd2);
        data[0] = 32'hA5A5_A5A5;
        vld = 4'b0001;
        step(4'b0001, "s1_ack");
        vld = 4'b0000;
        @(negedge clk);
        check("s1_pkt", 64'(pkt_out), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hA5A5_A5A5}));
        check("s1_busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("s1_idle_vld", 64'(pkt_out[48]), 64'(0));
        check("s1_idle_hold", 64'(pkt_out[47:0]), 64'({5'd3, 4'd2, 7'd0, 32'hA5A5_A5A5}));
        @(posedge clk); #1;

        // Round-robin
        do_reset();
        for (int i = 0; i < NP; i++) cfg_write(i, 1'b1, 5'(8 + i), 4'(i));
        for (int i = 0; i < NP; i++) data[i] = 32'h1111_1111 * (i + 1);
        vld = 4'hF;
        step(4'b0001, "rr0"); step(4'b0010, "rr1"); step(4'b0100, "rr2");
        step(4'b1000, "rr3"); step(4'b0001, "rr4"); step(4'b0010, "rr5");
        vld = 4'b0;
        step(4'b0000, "rr_idle");

        // Backpressure with same-cycle refill
        vld = 4'b0001;
        held = {1'b1, m_leaf[0], m_port[0], m_seq[0], data[0]};
        step(4'b0001, "bp_first");
        pkt_rdy = 1'b0;
        data[0] = 32'hDEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ack", 64'(ack), 64'(0));
            check("bp_busy", 64'(busy), 64'(1));
            check("bp_hold", 64'(pkt_out), 64'(held));
            @(posedge clk); #1;
        end
        pkt_rdy = 1'b1;
        step(4'b0001, "bp_refill");
        vld = 4'b0;
        step(4'b0000, "bp_idle");

        // Credit exhaustion on port 1
        do_reset();
        cfg_write(0, 1'b1, 5'd1, 4'd1);
        cfg_write(1, 1'b1, 5'd2, 4'd3);
        data[0] = 32'h0000_00C0;
        data[1] = 32'h0000_00C1;
        vld = 4'b0010;
        for (int c = 0; c < 64; c++) step(4'b0010, "cr_spend");
        vld = 4'b0011;
        step(4'b0001, "cr_skip0");
        step(4'b0001, "cr_skip1");
        vld = 4'b0010;
        credit_ret = 4'b0010;
        step(4'b0000, "cr_ret_nogrant");
        credit_ret = 4'b0000;
        step(4'b0010, "cr_one_more");
        step(4'b0000, "cr_empty_again");
        credit_ret = 4'b0010;
        step(4'b0000, "cr_ret2");
        step(4'b0010, "cr_grant_and_ret");
        credit_ret = 4'b0000;
        step(4'b0010, "cr_kept_one");
        step(4'b0000, "cr_empty_final");
        vld = 4'b0;
        step(4'b0000, "cr_idle");

        // Sequence wrap on port 2 (returns keep the credit level constant)
        do_reset();
        cfg_write(2, 1'b1, 5'd17, 4'd9);
        vld = 4'b0100;
        credit_ret = 4'b0100;
        for (int c = 0; c < 130; c++) begin
            data[2] = 32'h2000_0000 + c;
            step(4'b0100, "seq_grant");
        end
        vld = 4'b0; credit_ret = 4'b0;
        step(4'b0000, "seq_idle");

        // Reset mid-transfer
        do_reset();
        cfg_write(3, 1'b1, 5'd30, 4'd15);
        data[3] = 32'h3333_CAFE;
        vld = 4'b1000;
        step(4'b1000, "mr_grant");
        pkt_rdy = 1'b0;
        vld = 4'b0;
        @(negedge clk);
        check("mr_busy", 64'(busy), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("mr_pkt_clear", 64'(pkt_out), 64'(0));
        check("mr_busy_clear", 64'(busy), 64'(0));
        model_clear();
        @(posedge clk); #1;
        reset = 1'b1;
        pkt_rdy = 1'b1;
        vld = 4'hF;
        for (int c = 0; c < 3; c++) step(4'b0000, "mr_disabled");
        vld = 4'b0;
        for (int i = 0; i < NP; i++) cfg_write(i, 1'b1, 5'(20 + i), 4'(i + 4));
        for (int i = 0; i < NP; i++) data[i] = 32'h4000_0000 + i;
        vld = 4'hF;
        step(4'b0001, "mr_first_port0");
        step(4'b0010, "mr_second");
        vld = 4'b0;
        step(4'b0000, "mr_idle");
        step(4'b0000, "mr_idle2");

        check("drain", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
